dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory slave on the far end of the core's load/store request interface.
- Accepts one store or load request at a time from the CU-side master. Stores write an internal word-organised array under byte mask; loads return right-aligned data.
- Each response arrives after a programmable latency, so the NPC can be moved from ideal single-cycle memory to a multi-cycle handshake.
- Stores take CPU-side unshifted data plus an address-shifted lane mask. Loads take a size mask, and the responder does the lane extraction.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of array word 0.
- DEPTH, 1024, number of 32-bit words (power of two).
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range is 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, unshifted (byte/half in low bits)
- req_wmask  in  8  store lane mask: 01/02/04/08 byte, 03/0c half, ff word
- req_rmask  in  8  load size: 01 byte, 02 half, ff word
- rsp_valid  out  1  response present
- rsp_ready  in  1  master takes response
- rsp_rdata  out  32  load data, right-aligned, upper bits zero; 0 for stores
- rsp_err  out  1  access fault

Interface decision: one clock, clk; reset rst_n is synchronous and active-low.

Behaviour:
- States are IDLE, WAIT and RESP.
- req_ready = (state == IDLE). A request is accepted at the edge where req_valid && req_ready.
- Accept edge (store, no error): each byte lane i with wmask[i] set receives byte (req_wdata << 8*addr[1:0]) lane i. Mask ff writes all 4 lanes, with no shift.
- Accept edge (load): the addressed word is read into rdata_q.
  - Byte load: rdata_q = {24'h0, word byte addr[1:0]}.
  - Half load: rdata_q = {16'h0, word half addr[1]}.
  - Word load: rdata_q = word.
- Error checks at accept. On error, stores write nothing, rdata_q = 0 and err_q = 1. Errors are:
  - word index (addr - BASE_ADDR) >> 2 >= DEPTH, or addr < BASE_ADDR;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0;
  - mask encoding not listed in Ports.
- Transitions:
  - IDLE to RESP when LATENCY = 1. IDLE to WAIT otherwise, loading cnt = LATENCY - 2.
  - WAIT: cnt decrements; when cnt == 0, go to RESP. Request acceptance is cycle T; rsp_valid first rises in cycle T + LATENCY.
  - RESP: rsp_valid = 1, and rsp_rdata/rsp_err are held stable until the edge with rsp_ready = 1, then go to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake; there is no same-cycle bypass.
- Only one request is outstanding at a time. req_* inputs are ignored outside IDLE.
- A load following a store to the same address returns the stored data.
- Reset (rst_n = 0 at an edge): state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, cnt = 0. req_ready is therefore 1 after the first release edge.
  - Reset mid-operation aborts the transaction with no response.
  - A store already accepted stays written. Array contents are never cleared by reset.
- rsp_ready held high while in IDLE or WAIT has no effect.

Optional Feature:
- Macro: DMEM_RESPONDER_JITTER_EN.
- When defined: an 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5) advances every cycle. At accept, lfsr[1:0] extra cycles (0..3) are added to the latency. The LATENCY = 1 case then also passes through WAIT whenever jitter is nonzero.
- When undefined: latency is exactly LATENCY, and the LFSR logic is absent.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - mask constants MASK_B0..MASK_B3, MASK_H0, MASK_H1, MASK_W, RMASK_B, RMASK_H, RMASK_W;
  - the LFSR seed.
- Sub-module dmem_lane_align, purely combinational:
  - inputs: word, addr[1:0], wdata, wmask, rmask;
  - outputs: per-lane write enables, shifted write data, extracted load data, mask/alignment error.

Test Plan:
- Reset, then store word 32'hDEADBEEF at 8000_0010 with wmask ff, then load word with rmask ff (LATENCY = 2) -> rsp_valid in T+2 for each request; load rdata = DEADBEEF, err = 0.
- Store byte 8'h5A at 8000_0013 (wdata 0000_005A, wmask 08), then load word -> 5AADBEEF. Load byte at 8000_0013 -> 0000_005A.
- Store half 16'h1234 at 8000_0012 (wmask 0c), then load half at 8000_0012 -> 0000_1234. Half load at 8000_0011 -> err = 1, rdata = 0.
- Store word at 8000_1000 (DEPTH = 1024, out of range) -> err = 1. A following load at 8000_0000 returns its prior value, unchanged.
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid -> rsp_valid/rdata stable and req_ready = 0 throughout. A new req_valid is accepted only in the cycle after the handshake.
- Assert rst_n = 0 in WAIT after a store accept -> rsp_valid never rises, req_ready = 1 after release, and a subsequent load returns the stored data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// store/load mask encodings and the jitter LFSR seed.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [7:0] MASK_B0 = 8'h01;
   localparam logic [7:0] MASK_B1 = 8'h02;
   localparam logic [7:0] MASK_B2 = 8'h04;
   localparam logic [7:0] MASK_B3 = 8'h08;
   localparam logic [7:0] MASK_H0 = 8'h03;
   localparam logic [7:0] MASK_H1 = 8'h0c;
   localparam logic [7:0] MASK_W  = 8'hff;

   localparam logic [7:0] RMASK_B = 8'h01;
   localparam logic [7:0] RMASK_H = 8'h02;
   localparam logic [7:0] RMASK_W = 8'hff;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store lane enables and shifted data,
// right-aligned load extraction, and mask/alignment fault detection.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic        wen,
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   input  logic [7:0]  wmask,
   input  logic [7:0]  rmask,
   output logic [3:0]  lane_we,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata,
   output logic        align_err
);

   logic [31:0] word_sh;

   always_comb begin
      lane_we   = '0;
      wdata_sh  = wdata << {addr, 3'b000};
      word_sh   = word >> {addr, 3'b000};
      rdata     = '0;
      align_err = 1'b0;
      if (wen) begin
         case (wmask)
            MASK_B0, MASK_B1, MASK_B2, MASK_B3: lane_we = wmask[3:0];
            MASK_H0, MASK_H1: begin
               if (addr[0]) align_err = 1'b1;
               else         lane_we   = wmask[3:0];
            end
            MASK_W: begin
               if (addr != 2'b00) align_err = 1'b1;
               else               lane_we   = 4'hf;
            end
            default: align_err = 1'b1;
         endcase
      end else begin
         case (rmask)
            RMASK_B: rdata = {24'h0, word_sh[7:0]};
            RMASK_H: begin
               if (addr[0]) align_err = 1'b1;
               else         rdata     = {16'h0, word_sh[15:0]};
            end
            RMASK_W: begin
               if (addr != 2'b00) align_err = 1'b1;
               else               rdata     = word;
            end
            default: align_err = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave with a programmable response latency.
// Define DMEM_RESPONDER_JITTER_EN to add 0..3 LFSR-driven extra cycles per request.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [7:0]  req_wmask,
   input  logic [7:0]  req_rmask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH];
   logic [29:0] word_off;
   logic [IDX_W-1:0] idx;
   logic [31:0] word, wdata_sh, ld_data;
   logic [3:0]  lane_we;
   logic        align_err, range_err, acc_err, accept;
   logic [1:0]  jitter;
   logic [4:0]  lat_eff;

   assign word_off  = 30'((req_addr - BASE_ADDR) >> 2);
   assign idx       = word_off[IDX_W-1:0];
   assign word      = mem[idx];
   assign range_err = (req_addr < BASE_ADDR) || (word_off >= 30'(DEPTH));
   assign acc_err   = range_err || align_err;
   assign accept    = req_valid && (state_q == IDLE);

   dmem_lane_align u_align (
      .wen       (req_wen),
      .word      (word),
      .addr      (req_addr[1:0]),
      .wdata     (req_wdata),
      .wmask     (req_wmask),
      .rmask     (req_rmask),
      .lane_we   (lane_we),
      .wdata_sh  (wdata_sh),
      .rdata     (ld_data),
      .align_err (align_err)
   );

`ifdef DMEM_RESPONDER_JITTER_EN
   logic [7:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   assign jitter = lfsr_q[1:0];
`else
   assign jitter = '0;
`endif

   assign lat_eff = 5'(LATENCY) + {3'b000, jitter};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               err_d   = acc_err;
               rdata_d = (acc_err || req_wen) ? '0 : ld_data;
               if (lat_eff == 5'd1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = lat_eff - 5'd2;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - 5'd1;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Array is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (rst_n && accept && req_wen && !acc_err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (lane_we[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default build, LATENCY = 2).
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [7:0]  req_wmask, req_rmask;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dmem_responder #(
      .BASE_ADDR (32'h8000_0000),
      .DEPTH     (1024),
      .LATENCY   (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .req_rmask (req_rmask),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   // Issue one request, measure cycles from acceptance to rsp_valid, complete the handshake.
   task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [7:0] wmask, input logic [7:0] rmask,
                         output logic [31:0] rdata, output logic err, output int lat);
      int guard;
      @(negedge clk);
      req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
      req_wmask = wmask; req_rmask = rmask; rsp_ready = 1'b1;
      guard = 0;
      while (req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
      if (req_ready !== 1'b1) begin
         vectors++; miscompares++;
         $display("FAIL req_accept_timeout: req_ready=%b required 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
      rdata = rsp_rdata; err = rsp_err;
      if (rsp_valid !== 1'b1) begin
         vectors++; miscompares++;
         $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_wen = 1'b0;
      req_addr = '0; req_wdata = '0; req_wmask = '0; req_rmask = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
      vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_rdata: got %h required 00000000", rsp_rdata); end
      vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b required 0", rsp_err); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
   endtask

   task automatic test_word();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'hff, 8'h00, rd, er, lat);
      vectors++; if (lat != 2) begin miscompares++; $display("FAIL word_store_latency: got %0d required 2", lat); end
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL word_store_err: got %b required 0", er); end
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL word_store_rdata: got %h required 00000000", rd); end
      do_req(1'b0, 32'h8000_0010, 32'h0, 8'h00, 8'hff, rd, er, lat);
      vectors++; if (lat != 2) begin miscompares++; $display("FAIL word_load_latency: got %0d required 2", lat); end
      vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL word_load_rdata: got %h required deadbeef", rd); end
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL word_load_err: got %b required 0", er); end
   endtask

   task automatic test_byte();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h8000_0013, 32'h0000_005A, 8'h08, 8'h00, rd, er, lat);
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL byte_store_err: got %b required 0", er); end
      do_req(1'b0, 32'h8000_0010, 32'h0, 8'h00, 8'hff, rd, er, lat);
      vectors++; if (rd !== 32'h5AAD_BEEF) begin miscompares++; $display("FAIL byte_merge_word: got %h required 5aadbeef", rd); end
      do_req(1'b0, 32'h8000_0013, 32'h0, 8'h00, 8'h01, rd, er, lat);
      vectors++; if (rd !== 32'h0000_005A) begin miscompares++; $display("FAIL byte_load_lane3: got %h required 0000005a", rd); end
      do_req(1'b0, 32'h8000_0011, 32'h0, 8'h00, 8'h01, rd, er, lat);
      vectors++; if (rd !== 32'h0000_00BE || er !== 1'b0) begin miscompares++; $display("FAIL byte_load_lane1: got %h/%b required 000000be/0", rd, er); end
   endtask

   task automatic test_half();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h8000_0012, 32'h0000_1234, 8'h0c, 8'h00, rd, er, lat);
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL half_store_err: got %b required 0", er); end
      do_req(1'b0, 32'h8000_0012, 32'h0, 8'h00, 8'h02, rd, er, lat);
      vectors++; if (rd !== 32'h0000_1234) begin miscompares++; $display("FAIL half_load_hi: got %h required 00001234", rd); end
      do_req(1'b0, 32'h8000_0010, 32'h0, 8'h00, 8'h02, rd, er, lat);
      vectors++; if (rd !== 32'h0000_BEEF) begin miscompares++; $display("FAIL half_load_lo: got %h required 0000beef", rd); end
      do_req(1'b0, 32'h8000_0011, 32'h0, 8'h00, 8'h02, rd, er, lat);
      vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL half_misaligned: got err=%b rdata=%h required 1/00000000", er, rd); end
      do_req(1'b0, 32'h8000_0012, 32'h0, 8'h00, 8'hff, rd, er, lat);
      vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL word_misaligned: got err=%b rdata=%h required 1/00000000", er, rd); end
      do_req(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'h05, 8'h00, rd, er, lat);
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL bad_wmask_err: got %b required 1", er); end
      do_req(1'b0, 32'h8000_0010, 32'h0, 8'h00, 8'hff, rd, er, lat);
      vectors++; if (rd !== 32'h1234_BEEF) begin miscompares++; $display("FAIL half_merge_word: got %h required 1234beef", rd); end
   endtask

   task automatic test_range();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 8'hff, 8'h00, rd, er, lat);
      do_req(1'b1, 32'h8000_1000, 32'h1111_2222, 8'hff, 8'h00, rd, er, lat);
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL range_store_err: got %b required 1", er); end
      do_req(1'b0, 32'h8000_0000, 32'h0, 8'h00, 8'hff, rd, er, lat);
      vectors++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin miscompares++; $display("FAIL range_word0_intact: got %h/%b required cafef00d/0", rd, er); end
      do_req(1'b1, 32'h8000_0FFC, 32'h0A0B_0C0D, 8'hff, 8'h00, rd, er, lat);
      do_req(1'b0, 32'h8000_0FFC, 32'h0, 8'h00, 8'hff, rd, er, lat);
      vectors++; if (rd !== 32'h0A0B_0C0D || er !== 1'b0) begin miscompares++; $display("FAIL range_last_word: got %h/%b required 0a0b0c0d/0", rd, er); end
      do_req(1'b0, 32'h7FFF_FFFC, 32'h0, 8'h00, 8'hff, rd, er, lat);
      vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL range_below_base: got err=%b rdata=%h required 1/00000000", er, rd); end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic er; int lat;
      int guard;
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_rmask = 8'hff; rsp_ready = 1'b0;
      @(posedge clk); #1;
      // Present a second request that must wait for the handshake.
      req_wen = 1'b1; req_addr = 32'h8000_0030; req_wdata = 32'h5566_7788; req_wmask = 8'hff;
      guard = 0;
      while (rsp_valid !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_BEEF || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_hold[%0d]: valid=%b rdata=%h ready=%b required 1/1234beef/0", i, rsp_valid, rsp_rdata, req_ready);
         end
         @(posedge clk); #1;
      end
      @(negedge clk); rsp_ready = 1'b1;
      @(posedge clk); #1; rsp_ready = 1'b0;
      vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_after_handshake: valid=%b ready=%b required 0/1", rsp_valid, req_ready); end
      @(posedge clk); #1; req_valid = 1'b0;
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_next_accept: ready=%b required 0", req_ready); end
      guard = 0;
      while (rsp_valid !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
      vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL bp_second_rsp: valid=%b err=%b required 1/0", rsp_valid, rsp_err); end
      rsp_ready = 1'b1;
      @(posedge clk); #1; rsp_ready = 1'b0;
      do_req(1'b0, 32'h8000_0030, 32'h0, 8'h00, 8'hff, rd, er, lat);
      vectors++; if (rd !== 32'h5566_7788) begin miscompares++; $display("FAIL bp_second_store_data: got %h required 55667788", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat;
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0040; req_wdata = 32'h1122_3344;
      req_wmask = 8'hff; rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0; rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid[%0d]: got %b required 0", i, rsp_valid); end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_release[%0d]: ready=%b valid=%b required 1/0", i, req_ready, rsp_valid); end
      end
      do_req(1'b0, 32'h8000_0040, 32'h0, 8'h00, 8'hff, rd, er, lat);
      vectors++; if (rd !== 32'h1122_3344 || er !== 1'b0) begin miscompares++; $display("FAIL midreset_store_kept: got %h/%b required 11223344/0", rd, er); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_range();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
